// File: rtl/acc_proc_pkg.sv
// Shared opcode and state definitions for the accumulator processor core.
package acc_proc_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_LDA  = 4'h0,
    OP_STA  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_IN   = 4'h7,
    OP_OUT  = 4'h8,
    OP_JMP  = 4'h9,
    OP_JZ   = 4'hA,
    OP_JPOS = 4'hB,
    OP_JC   = 4'hC,
    OP_SHL  = 4'hD,
    OP_SHR  = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WBACK,
    ST_WAIT_IN,
    ST_WAIT_OUT,
    ST_HALTED
  } state_e;

endpackage

// File: rtl/acc_proc_ram.sv
// Single-port program/data RAM with synchronous read; shared by fetch, operand access and the load port.
module acc_proc_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: no reset here -- RAM arrays cannot be reset in one cycle, and program contents must survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/acc_proc_core.sv
// Multi-cycle accumulator processor: FETCH/DECODE/EXEC(/WBACK) sequencing over a shared RAM,
// with ready/valid input and output ports and an external program load/readback port.
module acc_proc_core
  import acc_proc_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  output logic [DATA_W-1:0] prog_rdata,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic [DATA_W-1:0] a_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic              zero,
  output logic              pos,
  output logic              carry,
  output logic              ovf
);

  localparam int MSB = DATA_W - 1;

  state_e            state, state_d;
  logic [DATA_W-1:0] a, a_d, ir, ir_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic              carry_d, ovf_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_q;

  opcode_e           op;
  logic [ADDR_W-1:0] opd;
  logic [DATA_W:0]   sum, diff;
  logic              idle_like;

  assign op        = opcode_e'(ir[DATA_W-1 -: OPC_W]);
  assign opd       = ir[ADDR_W-1:0];
  assign idle_like = (state == ST_IDLE) || (state == ST_HALTED);

  // Top bit of the widened difference is the unsigned borrow (A < M).
  assign sum  = {1'b0, a} + {1'b0, mem_q};
  assign diff = {1'b0, a} - {1'b0, mem_q};

  acc_proc_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .q     (mem_q)
  );

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state;
    a_d       = a;
    pc_d      = pc;
    ir_d      = ir;
    carry_d   = carry;
    ovf_d     = ovf;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = prog_addr;
    mem_wdata = prog_wdata;

    case (state)
      ST_IDLE, ST_HALTED: begin
        mem_we = prog_we;
        if (start) begin
          pc_d    = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_addr = pc;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = mem_q;
        pc_d    = pc + ADDR_W'(1);
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        mem_addr = opd;
        state_d  = ST_FETCH;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = ST_WBACK;
          OP_STA: begin
            mem_we    = 1'b1;
            mem_wdata = a;
          end
          OP_IN:   state_d = ST_WAIT_IN;
          OP_OUT:  state_d = ST_WAIT_OUT;
          OP_JMP:  pc_d = opd;
          OP_JZ:   if (a == '0) pc_d = opd;
          OP_JPOS: if (!a[MSB]) pc_d = opd;
          OP_JC:   if (carry) pc_d = opd;
          OP_SHL: begin
            carry_d = a[MSB];
            a_d     = {a[MSB-1:0], 1'b0};
          end
          OP_SHR: begin
            carry_d = a[0];
            a_d     = {1'b0, a[MSB:1]};
          end
          default: state_d = ST_HALTED;
        endcase
      end
      ST_WBACK: begin
        state_d = ST_FETCH;
        case (op)
          OP_LDA: a_d = mem_q;
          OP_ADD: begin
            a_d     = sum[MSB:0];
            carry_d = sum[DATA_W];
            ovf_d   = (a[MSB] == mem_q[MSB]) && (sum[MSB] != a[MSB]);
          end
          OP_SUB: begin
            a_d     = diff[MSB:0];
            carry_d = diff[DATA_W];
            ovf_d   = (a[MSB] != mem_q[MSB]) && (diff[MSB] != a[MSB]);
          end
          OP_AND:  a_d = a & mem_q;
          OP_OR:   a_d = a | mem_q;
          OP_XOR:  a_d = a ^ mem_q;
          default: ;
        endcase
      end
      ST_WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_data;
          state_d = ST_FETCH;
        end
      end
      ST_WAIT_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a     <= '0;
      pc    <= '0;
      ir    <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_d;
      a     <= a_d;
      pc    <= pc_d;
      ir    <= ir_d;
      carry <= carry_d;
      ovf   <= ovf_d;
    end
  end

  assign prog_rdata = mem_q;
  assign out_data   = a;
  assign a_out      = a;
  assign pc_out     = pc;
  assign ir_out     = ir;
  assign zero       = (a == '0);
  assign pos        = ~a[MSB];
  assign busy       = ~idle_like;
  assign halted     = (state == ST_HALTED);

endmodule
